cache_fill_arbiter: RTL and testbench
=====================================

Name: cache_fill_arbiter

Overview:
Shares one SDRAM burst-read port between NCLIENTS two-way cache instances, e.g. the 68k cache and the Z80/VDP cache. Each cache raises a fill request and holds it until it sees its fill strobe. It then latches four consecutive 16-bit words, critical word first. The arbiter picks one requester round-robin, forwards its burst address to the SDRAM controller, and steers the fill strobe to the granted cache only. The four-word data stream is broadcast to all clients.

Parameters:
NCLIENTS, 2, number of cache requesters (2..4).
ADDRBITS, 25, width of each client's word address (bits 25:1 of the byte address).
BURSTLEN, 4, words per fill burst, including the strobed first word.

Ports:
clk  in  1  system clock
reset_n  in  1  reset
client_req  in  NCLIENTS  per-client fill request; held high until that client's fill strobe
client_addr  in  NCLIENTS*ADDRBITS  per-client word address; client i occupies bits [i*ADDRBITS +: ADDRBITS]
client_fill  out  NCLIENTS  one-hot fill strobe; marks the first data word for the granted client
client_data  out  16  burst data, broadcast to all clients
mem_req  out  1  request to SDRAM controller
mem_addr  out  ADDRBITS  latched address of the granted client
mem_fill  in  1  controller strobe, first burst word valid on mem_data
mem_data  in  16  controller burst data
grant  out  NCLIENTS  one-hot current owner; all zero when idle
busy  out  1  high from grant until the burst completes

Behaviour:
- Single clock domain, clk.
- Reset: asynchronous, active-low (reset_n). While asserted:
  - mem_req=0, mem_addr=0, grant=0, busy=0.
  - State = IDLE.
  - Round-robin pointer = client 0 highest priority.
- Combinational paths:
  - client_data = mem_data at all times.
  - client_fill = grant & {NCLIENTS{mem_fill}}, gated to 0 unless state is WAITFILL.
  - The cache samples the strobe and first word on the same edge, so these paths carry no register stage.
- IDLE:
  - If any client_req is high, pick the first requester at or after the pointer, wrapping at NCLIENTS-1 to 0.
  - Register grant, mem_addr (that client's address), mem_req=1 and busy=1; go to WAITFILL.
  - mem_req rises exactly 1 cycle after client_req is first sampled high.
- WAITFILL:
  - Hold mem_req=1 until mem_fill=1.
  - On mem_fill: mem_req<=0, burst counter<=1, go to BURST.
  - The pointer advances to grant+1 (mod NCLIENTS) on this edge.
- BURST:
  - Counter increments every cycle. There is no stall input; the controller delivers words on consecutive cycles.
  - When the counter reaches BURSTLEN-1 (the cycle carrying the last word), go to GAP.
- GAP:
  - One dead cycle with grant=0 and busy=0; return to IDLE.
  - Guarantees the served cache's registered req drop is visible before re-arbitration, so the same client is never double-served.
- Simultaneous requests: round-robin order. A client requesting while another is being served waits. Maximum wait is (NCLIENTS-1) full bursts plus its own.
- Client drops req during WAITFILL (abnormal):
  - mem_req is held until mem_fill anyway; the controller cannot abort.
  - client_fill is suppressed for that burst, and the data is discarded.
  - The burst still runs to completion through BURST and GAP.
- New requests arriving during BURST or GAP are ignored until IDLE. client_req is level-sensitive, so nothing is lost.
- mem_fill outside WAITFILL: ignored, never forwarded.
- Reset asserted mid-burst: immediate return to the reset state. Any burst in flight at the controller is the controller's responsibility; no client_fill is emitted after reset asserts.
- Widths: pointer and grant index are clog2(NCLIENTS) bits; the burst counter is clog2(BURSTLEN) bits and wraps only through the state change.

Test Plan:
- Single request: client 1 req with addr 0x012345 at cycle 10 -> mem_req=1, mem_addr=0x012345 at cycle 11. mem_fill at 15 with data 0xA001..0xA004 -> client_fill=2'b10 only at 15; client_data follows the stream; busy=0 and grant=0 at 19.
- Contention: both clients request at the same cycle after reset -> client 0 served first. Client 1's mem_req rises 1 cycle after the GAP cycle, with client 1's address.
- Fairness: both clients hold req continuously across 6 bursts -> grants alternate 0,1,0,1,0,1. client_fill never pulses for the non-granted client.
- Abort: client 0 drops req 2 cycles into WAITFILL -> mem_req stays high until mem_fill. client_fill stays 0; FSM returns to IDLE after 4 data cycles plus GAP.
- Spurious strobe: mem_fill pulsed while in IDLE -> client_fill=0, no state change.
- Reset mid-burst: reset_n low during the 2nd data word -> mem_req, grant and busy are 0 immediately. After release with client_req still high, a fresh request is issued 1 cycle after the first clk edge.

Source files
------------

// File: rtl/cache_fill_arbiter.sv
// Round-robin arbiter sharing one SDRAM burst-read port between cache fill
// requesters; forwards the winner's address and steers the fill strobe.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   client_req     per-client fill request, held until its fill strobe
//   client_addr    packed per-client word addresses (client i at i*ADDRBITS)
//   client_fill    one-hot strobe marking the first burst word for the owner
//   client_data    burst data, broadcast to every client
//   mem_req        request to the SDRAM controller
//   mem_addr       latched address of the granted client
//   mem_fill       controller strobe, first burst word valid on mem_data
//   mem_data       controller burst data
//   grant          one-hot current owner, zero when idle
//   busy           high from grant until the burst completes
module cache_fill_arbiter #(
    parameter int NCLIENTS = 2,
    parameter int ADDRBITS = 25,
    parameter int BURSTLEN = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [NCLIENTS-1:0]          client_req,
    input  logic [NCLIENTS*ADDRBITS-1:0] client_addr,
    output logic [NCLIENTS-1:0]          client_fill,
    output logic [15:0]                  client_data,
    output logic                         mem_req,
    output logic [ADDRBITS-1:0]          mem_addr,
    input  logic                         mem_fill,
    input  logic [15:0]                  mem_data,
    output logic [NCLIENTS-1:0]          grant,
    output logic                         busy
);

    localparam int IW = (NCLIENTS > 1) ? $clog2(NCLIENTS) : 1;
    localparam int SW = IW + 1;
    localparam int CW = (BURSTLEN > 2) ? $clog2(BURSTLEN) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BURSTLEN - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NCLIENTS - 1);
    localparam logic [SW-1:0] SCAN_N   = SW'(NCLIENTS);

    typedef enum logic [1:0] {
        IDLE,
        WAITFILL,
        BURST,
        GAP
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [IW-1:0]         ptr;
    logic [IW-1:0]         ptr_n;
    logic [IW-1:0]         gidx;
    logic [IW-1:0]         gidx_n;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_n;
    logic                  aborted;
    logic                  aborted_n;
    logic [NCLIENTS-1:0]   grant_n;
    logic [ADDRBITS-1:0]   addr_n;
    logic                  req_n;
    logic                  busy_n;

    logic                  pick_vld;
    logic [IW-1:0]         pick_idx;
    logic [SW-1:0]         scan;
    logic [ADDRBITS-1:0]   pick_addr;
    logic                  owner_live;
    logic [IW-1:0]         ptr_adv;

    // Scan requesters starting at the pointer, wrapping past the last client.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        scan     = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            scan = {1'b0, ptr} + SW'(k);
            if (scan >= SCAN_N) begin
                scan = scan - SCAN_N;
            end
            if (!pick_vld && client_req[scan[IW-1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        pick_addr = '0;
        for (int k = 0; k < NCLIENTS; k++) begin
            if (pick_idx == IW'(k)) begin
                pick_addr = client_addr[k*ADDRBITS +: ADDRBITS];
            end
        end
    end

    assign owner_live = |(grant & client_req);
    assign ptr_adv    = (gidx == IDX_LAST) ? '0 : gidx + IW'(1);

    // The cache latches the strobe and first word on the same edge, so both
    // paths stay combinational. A client that let go of its request while
    // waiting is never strobed for this burst, even if it re-requests.
    assign client_data = mem_data;

    always_comb begin
        client_fill = '0;
        if (state == WAITFILL && !aborted && owner_live) begin
            client_fill = grant & {NCLIENTS{mem_fill}};
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gidx_n    = gidx;
        cnt_n     = cnt;
        aborted_n = aborted;
        grant_n   = grant;
        addr_n    = mem_addr;
        req_n     = mem_req;
        busy_n    = busy;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n   = WAITFILL;
                    gidx_n    = pick_idx;
                    grant_n   = NCLIENTS'(1) << pick_idx;
                    addr_n    = pick_addr;
                    req_n     = 1'b1;
                    busy_n    = 1'b1;
                    aborted_n = 1'b0;
                end
            end
            WAITFILL: begin
                if (!owner_live) begin
                    aborted_n = 1'b1;
                end
                // The controller cannot abort, so the request stays up
                // until the first word arrives regardless of the client.
                if (mem_fill) begin
                    state_n = BURST;
                    req_n   = 1'b0;
                    cnt_n   = CW'(1);
                    ptr_n   = ptr_adv;
                end
            end
            BURST: begin
                cnt_n = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    state_n = GAP;
                    cnt_n   = '0;
                    grant_n = '0;
                    busy_n  = 1'b0;
                end
            end
            GAP: begin
                // Dead cycle so the served client's request drop is seen
                // before the next arbitration.
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            ptr      <= '0;
            gidx     <= '0;
            cnt      <= '0;
            aborted  <= 1'b0;
            grant    <= '0;
            mem_addr <= '0;
            mem_req  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            gidx     <= gidx_n;
            cnt      <= cnt_n;
            aborted  <= aborted_n;
            grant    <= grant_n;
            mem_addr <= addr_n;
            mem_req  <= req_n;
            busy     <= busy_n;
        end
    end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Randomized scoreboard bench for cache_fill_arbiter: a burst-level model
// predicts owner, address and timing; a monitor checks the DUT against it.
module tb_cache_fill_arbiter;

    localparam int NC = 2;
    localparam int AB = 25;
    localparam int BL = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic [NC-1:0]      client_req;
    logic [NC*AB-1:0]   client_addr;
    logic [NC-1:0]      client_fill;
    logic [15:0]        client_data;
    logic               mem_req;
    logic [AB-1:0]      mem_addr;
    logic               mem_fill;
    logic [15:0]        mem_data;
    logic [NC-1:0]      grant;
    logic               busy;

    cache_fill_arbiter #(
        .NCLIENTS(NC),
        .ADDRBITS(AB),
        .BURSTLEN(BL)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .client_req (client_req),
        .client_addr(client_addr),
        .client_fill(client_fill),
        .client_data(client_data),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_fill   (mem_fill),
        .mem_data   (mem_data),
        .grant      (grant),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               client;
        logic [AB-1:0]    addr;
        int               rise;
        int               fill;
        bit               abort;
        logic [BL*16-1:0] w;
    } burst_t;

    burst_t      bq[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    int          m_ptr;
    int          free_cyc;
    int          win_lo;
    int          win_hi;
    int          drop_cyc[NC];
    int          hold_off[NC];
    bit          rand_en;
    bit          spur_en;
    logic [15:0] sched[int];

    burst_t      cur;
    bit          mon_have;
    bit          prev_req;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    function automatic logic [NC-1:0] onehot(input int c);
        logic [NC-1:0] v;
        v    = '0;
        v[c] = 1'b1;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        cyc++;
        #2;
    endtask

    // Clients, controller and the round-robin model for the current cycle.
    task automatic model_cycle();
        int     n;
        int     p;
        int     j;
        int     f;
        burst_t b;
        n = cyc;
        for (int i = 0; i < NC; i++) begin
            if (drop_cyc[i] == n) begin
                client_req[i] = 1'b0;
                drop_cyc[i]   = -1;
            end else if (rand_en && !client_req[i] && drop_cyc[i] < 0 &&
                         n >= hold_off[i] && $urandom_range(2, 0) == 0) begin
                client_req[i] = 1'b1;
                client_addr[i*AB +: AB] = AB'($urandom);
            end
        end
        if (reset_n && n >= free_cyc && |client_req) begin
            p = -1;
            for (int k = 0; k < NC; k++) begin
                j = (m_ptr + k) % NC;
                if (p < 0 && client_req[j]) p = j;
            end
            f        = n + 1 + int'($urandom_range(4, 0));
            b.client = p;
            b.addr   = client_addr[p*AB +: AB];
            b.rise   = n + 1;
            b.fill   = f;
            b.abort  = rand_en && ($urandom_range(5, 0) == 0);
            for (int k = 0; k < BL; k++) begin
                b.w[k*16 +: 16] = 16'($urandom);
                sched[f+k]      = b.w[k*16 +: 16];
            end
            if (b.abort)
                drop_cyc[p] = int'($urandom_range(f, n + 1));
            else
                drop_cyc[p] = f + 1;
            hold_off[p] = f + 2 + int'($urandom_range(3, 0));
            // Nobody re-arbitrates before the fill edge, so moving the
            // pointer now is equivalent to moving it at the fill.
            m_ptr    = (p + 1) % NC;
            free_cyc = f + BL + 1;
            win_lo   = n + 1;
            win_hi   = f;
            bq.push_back(b);
        end
        mem_fill = (n == win_hi) ||
                   (spur_en && !(n >= win_lo && n <= win_hi) &&
                    $urandom_range(7, 0) == 0);
        mem_data = sched.exists(n) ? sched[n] : 16'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (!(client_req == '0 && cyc >= free_cyc && bq.size() == 0 &&
                 !mon_have) && t < 300) begin
            step();
            model_cycle();
            t++;
        end
        if (t >= 300) fail_now("drain_timeout");
    endtask

    initial begin : monitor
        mon_have = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_have = 1'b0;
                prev_req = 1'b0;
                bq.delete();
                continue;
            end
            if (mem_req && !prev_req) begin
                if (bq.size() == 0) begin
                    fail_now("unexpected_req");
                end else begin
                    cur      = bq.pop_front();
                    mon_have = 1'b1;
                    chk("req_cycle", cyc, cur.rise);
                    chk("grant", grant, onehot(cur.client));
                    chk("mem_addr", mem_addr, cur.addr);
                    chk("busy_on", busy, 1'b1);
                end
            end
            if (mon_have && cyc == cur.fill) begin
                chk("fill_strobe", client_fill,
                    cur.abort ? {NC{1'b0}} : onehot(cur.client));
                if (!cur.abort) chk("data_w0", client_data, cur.w[15:0]);
            end else begin
                chk("no_fill", client_fill, {NC{1'b0}});
            end
            if (mon_have && cyc < cur.fill) chk("req_hold", mem_req, 1'b1);
            if (mon_have && cyc > cur.fill && cyc < cur.fill + BL) begin
                chk("busy_burst", busy, 1'b1);
                if (!cur.abort)
                    chk("data_wn", client_data,
                        cur.w[(cyc-cur.fill)*16 +: 16]);
            end
            if (mon_have && cyc == cur.fill + 1) chk("req_drop", mem_req, 1'b0);
            if (mon_have && cyc == cur.fill + BL) begin
                chk("busy_gap", busy, 1'b0);
                chk("grant_gap", grant, {NC{1'b0}});
                mon_have = 1'b0;
            end
            prev_req = mem_req;
        end
    end

    initial begin : stim
        int t;
        reset_n     = 1'b0;
        client_req  = '0;
        client_addr = '0;
        mem_fill    = 1'b0;
        mem_data    = '0;
        m_ptr       = 0;
        free_cyc    = 0;
        win_lo      = -1;
        win_hi      = -2;
        rand_en     = 1'b0;
        spur_en     = 1'b0;
        for (int i = 0; i < NC; i++) begin
            drop_cyc[i] = -1;
            hold_off[i] = 0;
        end

        step();
        step();
        client_req = '1;
        mem_fill   = 1'b1;
        #1;
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, '0);
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_fill", client_fill, '0);
        client_req = '0;
        mem_fill   = 1'b0;

        step();
        reset_n  = 1'b1;
        free_cyc = cyc;
        rand_en  = 1'b1;
        spur_en  = 1'b1;
        model_cycle();
        repeat (2000) begin
            step();
            model_cycle();
        end
        rand_en = 1'b0;
        spur_en = 1'b0;
        drain();

        // Reset during the second data word, with the other client waiting.
        step();
        client_addr[0*AB +: AB] = AB'(25'h0_0abc1);
        client_addr[1*AB +: AB] = AB'(25'h0_12345);
        client_req = '1;
        model_cycle();
        t = 0;
        while (cyc < win_hi && t < 20) begin
            step();
            model_cycle();
            t++;
        end
        if (t >= 20) fail_now("fill_timeout");
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_req", mem_req, 1'b0);
        chk("mid_rst_grant", grant, '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_fill", client_fill, '0);
        model_cycle();
        m_ptr  = 0;
        win_lo = -1;
        win_hi = -2;
        repeat (2) begin
            step();
            model_cycle();
        end
        step();
        reset_n  = 1'b1;
        free_cyc = cyc;
        model_cycle();
        drain();

        chk("queue_empty", bq.size(), 0);
        chk("burst_closed", mon_have, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
